// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM encoding and sizing helpers for seq_match_counter and its bench
package seq_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int WIN_LEN_DEF = 64;
   localparam int CNT_W_DEF   = 8;
   localparam int THRESH_DEF  = 8;

   // Width of a counter that must reach win_len-1; never narrower than one bit.
   function automatic int cyc_width(input int win_len);
      return (win_len > 2) ? $clog2(win_len) : 1;
   endfunction

   function automatic int sat_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - CNT_W-wide saturating match accumulator with sticky overflow
// sum_o/ovf_o already include this cycle's increment so the window end can report them directly.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] sum_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             at_max;

   always_comb begin
      at_max = &cnt_q;
      sum_o  = (inc && !at_max) ? cnt_q + CNT_W'(1) : cnt_q;
      ovf_o  = ovf_q | (inc & at_max);
      cnt_d  = clr ? '0 : sum_o;
      ovf_d  = clr ? 1'b0 : ovf_o;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - windowed match-event counter with per-window report strobe
// Optional threshold alarm is compiled in with MATCH_ALARM_EN.
module seq_match_counter
   import seq_pkg::*;
#(
   parameter int WIN_LEN = WIN_LEN_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int THRESH  = THRESH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             match_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             cnt_valid_o,
   output logic             ovf_o,
   output logic             alarm_o,
   output logic             busy_o
);

   localparam int               CYC_W    = cyc_width(WIN_LEN);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WIN_LEN - 1);

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             acc_clr, acc_inc, acc_ovf, report;
   logic [CNT_W-1:0] acc_sum;

   sat_counter #(.CNT_W(CNT_W)) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (acc_clr),
      .inc   (acc_inc),
      .sum_o (acc_sum),
      .ovf_o (acc_ovf)
   );

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      acc_clr = 1'b1;
      acc_inc = 1'b0;
      report  = 1'b0;
      case (state_q)
         IDLE: begin
            cyc_d = '0;
            if (en) state_d = RUN;
         end
         RUN: begin
            acc_inc = match_i;
            // The last window cycle always completes, even with en low.
            if (cyc_q == CYC_LAST) begin
               report  = 1'b1;
               cnt_d   = acc_sum;
               ovf_d   = acc_ovf;
               valid_d = 1'b1;
               cyc_d   = '0;
               if (!en) state_d = IDLE;
            end else if (!en) begin
               state_d = IDLE;
               cyc_d   = '0;
            end else begin
               acc_clr = 1'b0;
               cyc_d   = cyc_q + CYC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef MATCH_ALARM_EN
   logic alarm_q, alarm_d;

   always_comb begin
      alarm_d = alarm_q;
      if (report) alarm_d = (32'(acc_sum) >= THRESH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) alarm_q <= 1'b0;
      else     alarm_q <= alarm_d;
   end

   assign alarm_o = alarm_q;
`else
   assign alarm_o = 1'b0;
`endif

   assign cnt_o       = cnt_q;
   assign cnt_valid_o = valid_q;
   assign ovf_o       = ovf_q;
   assign busy_o      = (state_q == RUN);

endmodule

// File: tb/tb_seq_match_counter.sv
// tb/tb_seq_match_counter.sv - table-driven scoreboard bench for seq_match_counter
// Alarm expectations follow MATCH_ALARM_EN.
module tb_seq_match_counter;
   import seq_pkg::*;

   localparam int WIN    = 8;
   localparam int CW     = 3;
   localparam int THR    = 4;
   localparam int NWIN   = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          match_i;
   logic [CW-1:0] cnt_o;
   logic          cnt_valid_o;
   logic          ovf_o;
   logic          alarm_o;
   logic          busy_o;

   typedef struct {
      logic [WIN-1:0] bits;
      int             cnt;
      logic           ovf;
   } win_t;

   typedef struct {
      int   cnt;
      logic ovf;
      logic alarm;
   } exp_t;

   win_t tbl [NWIN];
   exp_t sb[$];
   int   stamps[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc_n    = 0;

   seq_match_counter #(.WIN_LEN(WIN), .CNT_W(CW), .THRESH(THR)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .match_i     (match_i),
      .cnt_o       (cnt_o),
      .cnt_valid_o (cnt_valid_o),
      .ovf_o       (ovf_o),
      .alarm_o     (alarm_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic exp_alarm(input int c);
`ifdef MATCH_ALARM_EN
      return (c >= THR);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one cycle; outputs are sampled on the falling edge, clear of the active edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc_n++;
      if (cnt_valid_o === 1'b1) begin
         stamps.push_back(cyc_n);
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(cnt_valid_o), 32'd0);
         end else begin
            e = sb.pop_front();
            check("cnt", 32'(cnt_o), 32'(e.cnt));
            check("ovf", 32'(ovf_o), 32'(e.ovf));
            check("alarm", 32'(alarm_o), 32'(e.alarm));
         end
      end
   endtask

   task automatic push_exp(input int c, input logic o);
      exp_t e;
      e.cnt   = c;
      e.ovf   = o;
      e.alarm = exp_alarm(c);
      sb.push_back(e);
   endtask

   // Drives one full window; en already high and the FSM aligned to cycle 0.
   task automatic run_window(input logic [WIN-1:0] bits, input int c, input logic o,
                             input logic drop_last);
      push_exp(c, o);
      for (int k = 0; k < WIN; k++) begin
         match_i = bits[k];
         if (drop_last && k == WIN - 1) en = 1'b0;
         tick();
      end
   endtask

   initial begin
      tbl[0] = '{8'b1000_1001, 3, 1'b0};
      tbl[1] = '{8'b1111_1111, 7, 1'b1};
      tbl[2] = '{8'b0000_0011, 2, 1'b0};
      tbl[3] = '{8'b0101_0101, 4, 1'b0};
      tbl[4] = '{8'b0000_0111, 3, 1'b0};
      tbl[5] = '{8'b0111_1111, 7, 1'b0};
      tbl[6] = '{8'b0000_0000, 0, 1'b0};
      tbl[7] = '{8'b1111_0000, 4, 1'b0};

      rst = 1'b1;
      en = 1'b0;
      match_i = 1'b0;
      repeat (3) tick();
      check("rst_cnt", 32'(cnt_o), 32'd0);
      check("rst_valid", 32'(cnt_valid_o), 32'd0);
      check("rst_ovf", 32'(ovf_o), 32'd0);
      check("rst_alarm", 32'(alarm_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      tick();
      check("idle_busy", 32'(busy_o), 32'd0);

      en = 1'b1;
      tick();
      check("busy_rise", 32'(busy_o), 32'd1);

      stamps.delete();
      for (int i = 0; i < NWIN; i++)
         run_window(tbl[i].bits, tbl[i].cnt, tbl[i].ovf, i == NWIN - 1);
      check("busy_fall_complete", 32'(busy_o), 32'd0);
      check("valid_count", 32'(stamps.size()), 32'(NWIN));
      for (int i = 1; i < stamps.size(); i++)
         check("valid_gap", 32'(stamps[i] - stamps[i-1]), 32'(WIN));
      tick();
      check("valid_one_cycle", 32'(cnt_valid_o), 32'd0);

      // Abort at window cycle 4: no report, previous outputs retained.
      repeat (2) tick();
      en = 1'b1;
      match_i = 1'b1;
      tick();
      repeat (4) tick();
      en = 1'b0;
      tick();
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_cnt_hold", 32'(cnt_o), 32'd4);
      check("abort_ovf_hold", 32'(ovf_o), 32'd0);
      check("abort_alarm_hold", 32'(alarm_o), 32'(exp_alarm(4)));
      match_i = 1'b0;
      repeat (12) tick();
      check("abort_state", 32'(dut.state_q), 32'(IDLE));

      // Saturated report, then reset asserted mid-window.
      en = 1'b1;
      tick();
      run_window(8'hFF, 7, 1'b1, 1'b0);
      match_i = 1'b1;
      repeat (5) tick();
      check("pre_rst_cnt", 32'(cnt_o), 32'd7);
      check("pre_rst_ovf", 32'(ovf_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_cnt", 32'(cnt_o), 32'd0);
      check("mid_rst_valid", 32'(cnt_valid_o), 32'd0);
      check("mid_rst_ovf", 32'(ovf_o), 32'd0);
      check("mid_rst_alarm", 32'(alarm_o), 32'd0);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      en = 1'b0;
      match_i = 1'b0;
      tick();
      rst = 1'b0;
      repeat (12) tick();
      check("post_rst_cnt", 32'(cnt_o), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
